// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: pipeline writes have strict priority over
// a 2-entry queue of long-latency results, with a busy scoreboard for hazards.
//
// Ports:
//   clock, reset                  rising-edge clock, sync active-high reset
//   pipe_valid/address/strobe/data  pipeline write (always accepted)
//   long_issue_valid/address      long-latency op issued, marks dest busy
//   long_valid/ready/address/data result offer into the queue (handshake)
//   write_enabled/address/strobe/data  registered register-file write port
//   check_address_1/2, check_busy_1/2  operand hazard lookup (combinational)
//   queue_count                   result queue occupancy (0..2)

package cpu_core_params;
    typedef logic [31:0] cpu_data_t;
endpackage

module writeback_arbiter
    import cpu_core_params::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_address,
    input  logic [3:0]  pipe_strobe,
    input  logic [31:0] pipe_data,
    input  logic        long_issue_valid,
    input  logic [4:0]  long_issue_address,
    input  logic        long_valid,
    output logic        long_ready,
    input  logic [4:0]  long_address,
    input  logic [31:0] long_data,
    output logic        write_enabled,
    output logic [4:0]  write_address,
    output logic [3:0]  write_strobe,
    output logic [31:0] write_data,
    input  logic [4:0]  check_address_1,
    input  logic [4:0]  check_address_2,
    output logic        check_busy_1,
    output logic        check_busy_2,
    output logic [1:0]  queue_count
);

    logic [4:0] q_address [2];
    cpu_data_t  q_data    [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic       push;
    logic       pop;
    logic [4:0] head_address;
    cpu_data_t  head_data;
    logic [31:1] busy;
    logic [31:1] busy_next;

    // Ready comes from the registered count, so a pop this cycle
    // cannot make room for a push in the same cycle.
    assign long_ready = (queue_count < 2'd2);
    assign push       = long_valid && long_ready;

    // Registered count also keeps a same-cycle push out of reach of the pop.
    assign pop = !pipe_valid && (queue_count != 2'd0);

    assign head_address = q_address[rd_ptr];
    assign head_data    = q_data[rd_ptr];

    // Clear for the popped entry first, then set for a new issue,
    // so a newer issue to the same register wins.
    always_comb begin
        busy_next = busy;
        if (pop && head_address != 5'd0) begin
            busy_next[head_address] = 1'b0;
        end
        if (long_issue_valid && long_issue_address != 5'd0) begin
            busy_next[long_issue_address] = 1'b1;
        end
    end

    assign check_busy_1 = (check_address_1 != 5'd0) && busy[check_address_1];
    assign check_busy_2 = (check_address_2 != 5'd0) && busy[check_address_2];

    // Queue storage needs no reset; the pointers and count qualify it.
    always_ff @(posedge clock) begin
        if (push) begin
            q_address[wr_ptr] <= long_address;
            q_data[wr_ptr]    <= long_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            queue_count   <= 2'd0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            busy          <= '0;
            write_enabled <= 1'b0;
            write_address <= 5'd0;
            write_strobe  <= 4'h0;
            write_data    <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            queue_count <= queue_count + {1'b0, push} - {1'b0, pop};
            busy        <= busy_next;

            if (pipe_valid) begin
                write_enabled <= (pipe_address != 5'd0)
                                 && (pipe_strobe != 4'h0);
                write_address <= pipe_address;
                write_strobe  <= pipe_strobe;
                write_data    <= pipe_data;
            end else if (pop) begin
                write_enabled <= (head_address != 5'd0);
                write_address <= head_address;
                write_strobe  <= 4'hF;
                write_data    <= head_data;
            end else begin
                // Idle: address, strobe and data hold their values.
                write_enabled <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: per-cycle vector table with expected
// outputs, long-latency results tracked in a FIFO scoreboard.

module tb_writeback_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_address = '0;
    logic [3:0]  pipe_strobe = '0;
    logic [31:0] pipe_data = '0;
    logic        long_issue_valid = 1'b0;
    logic [4:0]  long_issue_address = '0;
    logic        long_valid = 1'b0;
    logic        long_ready;
    logic [4:0]  long_address = '0;
    logic [31:0] long_data = '0;
    logic        write_enabled;
    logic [4:0]  write_address;
    logic [3:0]  write_strobe;
    logic [31:0] write_data;
    logic [4:0]  check_address_1 = '0;
    logic [4:0]  check_address_2 = '0;
    logic        check_busy_1;
    logic        check_busy_2;
    logic [1:0]  queue_count;

    writeback_arbiter dut (
        .clock              (clock),
        .reset              (reset),
        .pipe_valid         (pipe_valid),
        .pipe_address       (pipe_address),
        .pipe_strobe        (pipe_strobe),
        .pipe_data          (pipe_data),
        .long_issue_valid   (long_issue_valid),
        .long_issue_address (long_issue_address),
        .long_valid         (long_valid),
        .long_ready         (long_ready),
        .long_address       (long_address),
        .long_data          (long_data),
        .write_enabled      (write_enabled),
        .write_address      (write_address),
        .write_strobe       (write_strobe),
        .write_data         (write_data),
        .check_address_1    (check_address_1),
        .check_address_2    (check_address_2),
        .check_busy_1       (check_busy_1),
        .check_busy_2       (check_busy_2),
        .queue_count        (queue_count)
    );

    always #5 clock = ~clock;

    // src: 0 = check enable only, 1 = this row's pipe write,
    //      2 = pop scoreboard head, 3 = reset zeros, 4 = held values
    typedef struct {
        logic        rst;
        logic        pv;
        logic [4:0]  pa;
        logic [3:0]  ps;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        keep;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  ca1;
        logic [4:0]  ca2;
        logic        ew;
        int          src;
        logic [1:0]  ecnt;
        logic        erdy;
        logic        eb1;
        logic        eb2;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } res_t;

    vec_t tbl[$];
    res_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [4:0]  last_a;
    logic [3:0]  last_s;
    logic [31:0] last_d;

    function automatic vec_t mk(
        logic rst, logic pv, logic [4:0] pa, logic [3:0] ps, logic [31:0] pd,
        logic lv, logic [4:0] la, logic [31:0] ld, logic keep,
        logic iv, logic [4:0] ia, logic [4:0] ca1, logic [4:0] ca2,
        logic ew, int src, logic [1:0] ecnt, logic erdy,
        logic eb1, logic eb2);
        vec_t v;
        v.rst = rst; v.pv = pv; v.pa = pa; v.ps = ps; v.pd = pd;
        v.lv = lv; v.la = la; v.ld = ld; v.keep = keep;
        v.iv = iv; v.ia = ia; v.ca1 = ca1; v.ca2 = ca2;
        v.ew = ew; v.src = src; v.ecnt = ecnt; v.erdy = erdy;
        v.eb1 = eb1; v.eb2 = eb2;
        return v;
    endfunction

    task automatic chk(string name, int row, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h",
                     name, row, act, exp);
        end
    endtask

    initial begin
        // rst pv pa ps pd | lv la ld keep | iv ia | ca1 ca2 |
        // ew src cnt rdy b1 b2
        // reset wins over every simultaneous input
        tbl.push_back(mk(1, 1,5,4'hF,32'h1, 1,3,32'h1,0, 1,3, 3,5,
                         0,3,0,1,0,0));
        // plain pipeline write
        tbl.push_back(mk(0, 1,5,4'hF,32'h12345678, 0,0,0,0, 0,0, 5,0,
                         1,1,0,1,0,0));
        // zero strobe: no enable
        tbl.push_back(mk(0, 1,6,4'h0,32'hDEAD, 0,0,0,0, 0,0, 0,0,
                         0,0,0,1,0,0));
        // priority: issue 7, queue {7,AA}, pipe holds 3 cycles
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,7, 7,0,
                         0,0,0,1,1,0));
        tbl.push_back(mk(0, 1,1,4'hF,32'h11, 1,7,32'hAA,1, 0,0, 7,0,
                         1,1,1,1,1,0));
        tbl.push_back(mk(0, 1,2,4'h3,32'h22, 0,0,0,0, 0,0, 7,0,
                         1,1,1,1,1,0));
        tbl.push_back(mk(0, 1,3,4'hF,32'h33, 0,0,0,0, 0,0, 7,0,
                         1,1,1,1,1,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 7,0,
                         1,2,0,1,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 7,0,
                         0,4,0,1,0,0));
        // push into empty queue is not popped the same cycle
        tbl.push_back(mk(0, 0,0,0,0, 1,8,32'h88,1, 0,0, 0,0,
                         0,4,1,1,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,
                         1,2,0,1,0,0));
        // fill queue under pipe pressure, third offer refused
        tbl.push_back(mk(0, 1,10,4'hF,32'h1010, 1,3,32'h1,1, 0,0, 0,0,
                         1,1,1,1,0,0));
        tbl.push_back(mk(0, 1,11,4'hF,32'h1111, 1,4,32'h2,1, 0,0, 0,0,
                         1,1,2,0,0,0));
        tbl.push_back(mk(0, 1,12,4'hF,32'h1212, 1,5,32'h3,0, 0,0, 0,0,
                         1,1,2,0,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 1,5,32'h3,0, 0,0, 0,0,
                         1,2,1,1,0,0));
        // push and pop together at count 1
        tbl.push_back(mk(0, 0,0,0,0, 1,5,32'h3,1, 0,0, 0,0,
                         1,2,1,1,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,
                         1,2,0,1,0,0));
        // scoreboard on register 9
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,9, 9,9,
                         0,4,0,1,1,1));
        tbl.push_back(mk(0, 0,0,0,0, 1,9,32'h99,1, 0,0, 9,8,
                         0,4,1,1,1,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 9,9,
                         1,2,0,1,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,9, 9,8,
                         0,4,0,1,1,0));
        tbl.push_back(mk(0, 0,0,0,0, 1,9,32'h9A,1, 0,0, 9,0,
                         0,4,1,1,1,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,9, 9,9,
                         1,2,0,1,1,1));
        // register 0: never enabled, never busy
        tbl.push_back(mk(0, 1,0,4'hF,32'h55, 0,0,0,0, 1,0, 0,9,
                         0,0,0,1,0,1));
        tbl.push_back(mk(0, 0,0,0,0, 1,0,32'hFF,1, 0,0, 0,0,
                         0,0,1,1,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,
                         0,2,0,1,0,0));
        // reset mid-operation with a full queue and busy[3]
        tbl.push_back(mk(0, 1,13,4'hF,32'h1313, 1,3,32'h31,0, 1,3, 3,9,
                         1,1,1,1,1,1));
        tbl.push_back(mk(0, 1,14,4'hF,32'h1414, 1,4,32'h41,0, 0,0, 3,9,
                         1,1,2,0,1,1));
        tbl.push_back(mk(1, 1,15,4'hF,32'h1515, 1,5,32'h51,0, 1,6, 3,9,
                         0,3,0,1,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 3,6,
                         0,4,0,1,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 1,20,32'h2020,1, 0,0, 3,4,
                         0,4,1,1,0,0));
        tbl.push_back(mk(0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,
                         1,2,0,1,0,0));

        last_a = '0;
        last_s = '0;
        last_d = '0;

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            res_t r;
            v = tbl[i];
            @(negedge clock);
            reset              = v.rst;
            pipe_valid         = v.pv;
            pipe_address       = v.pa;
            pipe_strobe        = v.ps;
            pipe_data          = v.pd;
            long_valid         = v.lv;
            long_address       = v.la;
            long_data          = v.ld;
            long_issue_valid   = v.iv;
            long_issue_address = v.ia;
            check_address_1    = v.ca1;
            check_address_2    = v.ca2;
            if (v.lv && v.keep) begin
                r.a = v.la;
                r.d = v.ld;
                sb.push_back(r);
            end
            @(posedge clock);
            #1;
            chk("write_enabled", i, 32'(write_enabled), 32'(v.ew));
            chk("queue_count", i, 32'(queue_count), 32'(v.ecnt));
            chk("long_ready", i, 32'(long_ready), 32'(v.erdy));
            chk("check_busy_1", i, 32'(check_busy_1), 32'(v.eb1));
            chk("check_busy_2", i, 32'(check_busy_2), 32'(v.eb2));
            case (v.src)
                1: begin
                    chk("pipe_address", i, 32'(write_address), 32'(v.pa));
                    chk("pipe_strobe", i, 32'(write_strobe), 32'(v.ps));
                    chk("pipe_data", i, write_data, v.pd);
                    last_a = v.pa;
                    last_s = v.ps;
                    last_d = v.pd;
                end
                2: begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard_empty row %0d", i);
                    end else begin
                        r = sb.pop_front();
                        if (v.ew) begin
                            chk("pop_address", i, 32'(write_address),
                                32'(r.a));
                            chk("pop_strobe", i, 32'(write_strobe),
                                32'hF);
                            chk("pop_data", i, write_data, r.d);
                            last_a = r.a;
                            last_s = 4'hF;
                            last_d = r.d;
                        end
                    end
                end
                3: begin
                    chk("reset_address", i, 32'(write_address), 32'd0);
                    chk("reset_strobe", i, 32'(write_strobe), 32'd0);
                    chk("reset_data", i, write_data, 32'd0);
                    last_a = '0;
                    last_s = '0;
                    last_d = '0;
                    sb.delete();
                end
                4: begin
                    chk("hold_address", i, 32'(write_address), 32'(last_a));
                    chk("hold_strobe", i, 32'(write_strobe), 32'(last_s));
                    chk("hold_data", i, write_data, last_d);
                end
                default: ;
            endcase
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0",
                     sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
